// File: rtl/led_seg_out_pkg.sv
// -----------------------------------------------------------------------------
// led_seg_out_pkg
// Shared I/O map for the CPU output port (LEDs + seven-segment display).
// Holds the store-address constants of this block next to the switch-input
// addresses, so both windows of the I/O decode path live in one place and
// cannot silently overlap. Also provides the write-target decode helper.
// -----------------------------------------------------------------------------
package led_seg_out_pkg;

  // Output-port window (this block)
  localparam logic [7:0] ADDR_LED_LO   = 8'h60;
  localparam logic [7:0] ADDR_LED_HI   = 8'h62;
  localparam logic [7:0] ADDR_SEG_LO   = 8'h80;
  localparam logic [7:0] ADDR_SEG_HI   = 8'h84;
  localparam logic [7:0] ADDR_SEG_MASK = 8'h88;

  // Input-port window (switch block); listed here so the maps stay disjoint
  localparam logic [7:0] ADDR_SW_0     = 8'h70;
  localparam logic [7:0] ADDR_SW_1     = 8'h74;
  localparam logic [7:0] ADDR_SW_2     = 8'h78;
  localparam logic [7:0] ADDR_SW_3     = 8'h7C;

  localparam int NUM_DIGITS = 8;
  localparam int NUM_LEDS   = 24;

  // Which register a store targets
  typedef enum logic [2:0] {
    SEL_NONE     = 3'd0,
    SEL_LED_LO   = 3'd1,
    SEL_LED_HI   = 3'd2,
    SEL_SEG_LO   = 3'd3,
    SEL_SEG_HI   = 3'd4,
    SEL_SEG_MASK = 3'd5
  } reg_sel_e;

  // Address decode; anything outside the map returns SEL_NONE
  function automatic reg_sel_e decode_addr(input logic [7:0] addr);
    reg_sel_e sel;
    sel = SEL_NONE;
    case (addr)
      ADDR_LED_LO:   sel = SEL_LED_LO;
      ADDR_LED_HI:   sel = SEL_LED_HI;
      ADDR_SEG_LO:   sel = SEL_SEG_LO;
      ADDR_SEG_HI:   sel = SEL_SEG_HI;
      ADDR_SEG_MASK: sel = SEL_SEG_MASK;
      default:       sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/led_seg_out_hex_to_seg.sv
// -----------------------------------------------------------------------------
// hex_to_seg
// Purely combinational hex-digit to seven-segment decoder.
// Ports:
//   i_nibble  in  4  hex value 0..F
//   o_seg     out 7  segments {g,f,e,d,c,b,a}, active-high
// Letters use the usual mixed-case glyphs: A b C d E F.
// -----------------------------------------------------------------------------
module hex_to_seg (
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'h00;
    case (i_nibble)
      4'h0: o_seg = 7'h3F;
      4'h1: o_seg = 7'h06;
      4'h2: o_seg = 7'h5B;
      4'h3: o_seg = 7'h4F;
      4'h4: o_seg = 7'h66;
      4'h5: o_seg = 7'h6D;
      4'h6: o_seg = 7'h7D;
      4'h7: o_seg = 7'h07;
      4'h8: o_seg = 7'h7F;
      4'h9: o_seg = 7'h6F;
      4'hA: o_seg = 7'h77;
      4'hB: o_seg = 7'h7C;
      4'hC: o_seg = 7'h39;
      4'hD: o_seg = 7'h5E;
      4'hE: o_seg = 7'h79;
      4'hF: o_seg = 7'h71;
      default: o_seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/led_seg_out.sv
// -----------------------------------------------------------------------------
// led_seg_out
// Memory-mapped CPU output port. Captures store data for 24 discrete LEDs and
// a 32-bit hex value shown on an 8-digit common-anode seven-segment display,
// scanned one digit at a time.
// Ports:
//   clk        in   1   system clock, rising edge
//   rst        in   1   synchronous active-high reset
//   LEDCtrl    in   1   write strobe from the I/O decoder
//   ALU_addr   in   8   low byte of store address
//   WriteData  in  16   store data
//   LEDOut     out 24   LED drive, active-high, registered
//   SegEn      out  8   digit anodes, active-low, registered (bit 0 = rightmost)
//   SegOut     out  8   cathodes {dp,g,f,e,d,c,b,a}, active-low, registered
// Parameter:
//   SCAN_DIV   clock cycles each digit stays lit (2..2^20)
//
// Bus handshake: LEDCtrl is a one-cycle store strobe with no back-pressure;
// every cycle with LEDCtrl=1 is a complete transfer of WriteData to the
// register selected by ALU_addr, so back-to-back stores are always accepted.
// -----------------------------------------------------------------------------
module led_seg_out
  import led_seg_out_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        LEDCtrl,
  input  logic [7:0]  ALU_addr,
  input  logic [15:0] WriteData,
  output logic [23:0] LEDOut,
  output logic [7:0]  SegEn,
  output logic [7:0]  SegOut
);

  localparam int                CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_DIV - 1);

  // Architectural state
  logic [NUM_LEDS-1:0] r_led;
  logic [31:0]         r_seg_val;
  logic [7:0]          r_dig_mask;
  logic [CNT_W-1:0]    r_scan_cnt;
  logic [2:0]          r_dig_idx;
  logic [7:0]          r_seg_en;
  logic [7:0]          r_seg_out;

  // Decode / datapath
  reg_sel_e            w_sel;
  logic                w_scan_wrap;
  logic [3:0]          w_nibble;
  logic [6:0]          w_seg_pat;
  logic                w_dig_on;

  assign w_sel       = LEDCtrl ? decode_addr(ALU_addr) : SEL_NONE;
  assign w_scan_wrap = (r_scan_cnt == CNT_LAST);

  // Single decoder on the nibble of the currently selected digit
  assign w_nibble    = r_seg_val[{r_dig_idx, 2'b00} +: 4];
  assign w_dig_on    = r_dig_mask[r_dig_idx];

  hex_to_seg u_hex_to_seg (
    .i_nibble (w_nibble),
    .o_seg    (w_seg_pat)
  );

  // Store capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_led      <= '0;
      r_seg_val  <= '0;
      r_dig_mask <= 8'hFF;
    end else begin
      case (w_sel)
        SEL_LED_LO:   r_led[15:0]      <= WriteData;
        SEL_LED_HI:   r_led[23:16]     <= WriteData[7:0];
        SEL_SEG_LO:   r_seg_val[15:0]  <= WriteData;
        SEL_SEG_HI:   r_seg_val[31:16] <= WriteData;
        SEL_SEG_MASK: r_dig_mask       <= WriteData[7:0];
        default: ;
      endcase
    end
  end

  // Digit scan: dwell SCAN_DIV cycles on each digit, then advance (mod 8)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan_cnt <= '0;
      r_dig_idx  <= '0;
    end else if (w_scan_wrap) begin
      r_scan_cnt <= '0;
      r_dig_idx  <= r_dig_idx + 3'd1;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  // Output registers follow the current digit and current register contents,
  // so a store to the lit digit shows up mid-dwell one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg_en  <= 8'hFF;
      r_seg_out <= 8'hFF;
    end else if (w_dig_on) begin
      r_seg_en  <= ~(8'h01 << r_dig_idx);
      r_seg_out <= ~{1'b0, w_seg_pat};
    end else begin
      r_seg_en  <= 8'hFF;
      r_seg_out <= 8'hFF;
    end
  end

  assign LEDOut = r_led;
  assign SegEn  = r_seg_en;
  assign SegOut = r_seg_out;

endmodule
